// File: rtl/coproc_mem_sequencer_if.sv
// Host/consumer/core-IO bundle for coproc_mem_sequencer.
// The slave modport is the sequencer's view; master is the host and core side.
interface coproc_mem_sequencer_if #(
  parameter int N      = 64,
  parameter int ADDR_W = 15,
  parameter int CNT_W  = 13
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_base;
  logic [CNT_W-1:0]  cmd_count;
  logic [N-1:0]      cmd_fill;
  logic              abort;
  logic              rd_valid;
  logic              rd_ready;
  logic [N-1:0]      rd_data;
  logic [ADDR_W-1:0] rd_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] io_addr;
  logic [4:0]        io_control;
  logic [N-1:0]      io_data_out;
  logic [N-1:0]      io_data_in;

  modport slave (
    input  cmd_valid, cmd_op, cmd_base, cmd_count, cmd_fill, abort, rd_ready, io_data_in,
    output cmd_ready, rd_valid, rd_data, rd_addr, busy, done, err, io_addr, io_control, io_data_out
  );

  modport master (
    output cmd_valid, cmd_op, cmd_base, cmd_count, cmd_fill, abort, rd_ready, io_data_in,
    input  cmd_ready, rd_valid, rd_data, rd_addr, busy, done, err, io_addr, io_control, io_data_out
  );
endinterface

// File: rtl/coproc_mem_sequencer.sv
// Walks the core's coprocessor IO memory port word by word to DUMP or FILL
// a byte-address range, holding each access for ACCESS_CYCLES cycles.
module coproc_mem_sequencer #(
  parameter int N             = 64,
  parameter int ADDR_W        = 15,
  parameter int CNT_W         = 13,
  parameter int ACCESS_CYCLES = 2,
  parameter int STRIDE        = 8
) (
  input  logic clk,
  input  logic reset,
  coproc_mem_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_OUT, S_DONE} state_e;

  localparam logic [4:0]        CTL_IDLE = 5'b00000;
  localparam logic [4:0]        CTL_RD   = 5'b00100;
  localparam logic [4:0]        CTL_WR   = 5'b00010;
  localparam int                CYC_W    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam logic [CYC_W-1:0]  CYC_LAST = CYC_W'(ACCESS_CYCLES - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [N-1:0]      fill_q, fill_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [N-1:0]      rd_data_q, rd_data_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic              last_word;
  logic [ADDR_W-1:0] next_addr;
  logic              misaligned;

  assign last_word  = (rem_q == CNT_W'(1));
  assign next_addr  = addr_q + STRIDE_A;
  assign misaligned = ((bus.cmd_base % STRIDE_A) != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      rem_q     <= '0;
      fill_q    <= '0;
      cyc_q     <= '0;
      rd_data_q <= '0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      fill_q    <= fill_d;
      cyc_q     <= cyc_d;
      rd_data_q <= rd_data_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    err_d     = err_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    fill_d    = fill_q;
    cyc_d     = cyc_q;
    rd_data_d = rd_data_q;
    rd_addr_d = rd_addr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          op_d   = bus.cmd_op;
          addr_d = bus.cmd_base;
          rem_d  = bus.cmd_count;
          fill_d = bus.cmd_fill;
          cyc_d  = '0;
          err_d  = 1'b0;
          if (bus.cmd_count == '0) begin
            state_d = S_DONE;
          end else if (misaligned) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (bus.abort) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (cyc_q == CYC_LAST) begin
          cyc_d = '0;
          if (op_q) begin
            rem_d   = rem_q - CNT_W'(1);
            addr_d  = next_addr;
            state_d = last_word ? S_DONE : S_ACCESS;
          end else begin
            rd_data_d = bus.io_data_in;
            rd_addr_d = addr_q;
            state_d   = S_OUT;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      // abort takes priority over a coincident consumer handshake
      S_OUT: begin
        if (bus.abort) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else if (bus.rd_ready) begin
          rem_d   = rem_q - CNT_W'(1);
          addr_d  = next_addr;
          state_d = last_word ? S_DONE : S_ACCESS;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready   = (state_q == S_IDLE);
    bus.busy        = (state_q != S_IDLE);
    bus.done        = (state_q == S_DONE);
    bus.err         = (state_q == S_DONE) && err_q;
    bus.rd_valid    = (state_q == S_OUT);
    bus.rd_data     = rd_data_q;
    bus.rd_addr     = rd_addr_q;
    bus.io_addr     = addr_q;
    bus.io_control  = CTL_IDLE;
    bus.io_data_out = '0;
    if (state_q == S_ACCESS) begin
      bus.io_control = op_q ? CTL_WR : CTL_RD;
      if (op_q) bus.io_data_out = fill_q;
    end
  end

endmodule
